heartbeat_ctrl: RTL
===================

Name: heartbeat_ctrl

Overview:
Parametrised board-level control block. It debounces the pushbuttons, generates a stretched synchronous reset for downstream logic, and produces a programmable-rate slow clock with a tick strobe. It drives an LED bank in one of four key-selectable display modes. Sits at top level between the board I/O (KEY, LEDR) and the design core.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, clk_slow frequency in Hz; HALF = CLK_HZ/(2*TICK_HZ), must be >= 2
NUM_LEDS, 10, LED bank width; must be >= NUM_KEYS+1
NUM_KEYS, 2, pushbutton count; must be >= 2
DB_CYCLES, 500_000, debounce stability window in clk cycles (10 ms at 50 MHz); must be >= 1
RST_HOLD, 16, rst_out stretch length in clk cycles; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous assert, active-low
key  in  NUM_KEYS  raw pushbuttons, active-low; key[0] is soft reset, key[1] is mode step
ledr  out  NUM_LEDS  LED drive, active-high, registered
clk_slow  out  1  50% square wave at TICK_HZ
tick  out  1  one-cycle strobe on every clk_slow toggle
rst_out  out  1  active-high synchronous reset for downstream logic
mode  out  2  current display mode
key_db  out  NUM_KEYS  debounced key state, 1 = pressed
key_press  out  NUM_KEYS  one-cycle strobe on a debounced press

Behaviour:
- Reset values (rst low): ledr=0, clk_slow=0, tick=0, rst_out=1, mode=0, key_db=0, key_press=0, divider count=0, chase register=1 (bit 0). Key synchroniser flops reset to 1 (released).
- Synchroniser: 2-FF per key, inverted to active-high after sync.
- Debounce, per key:
  - Counter increments while the synced value differs from key_db and clears on any cycle where they match.
  - When the counter reaches DB_CYCLES, key_db takes the synced value and the counter clears.
  - Raw-edge to key_db latency is exactly DB_CYCLES+2 clk edges.
  - key_press[i] pulses for 1 cycle, on the cycle after key_db[i] rises.
  - Nothing is generated on release.
- Divider:
  - Counter runs 0..HALF-1.
  - At HALF-1 it wraps to 0, clk_slow toggles, and tick is high for that following cycle.
  - The divider free-runs and is unaffected by soft reset.
- Reset stretch:
  - rst_out is high during rst.
  - After rst deasserts, rst_out stays high for exactly RST_HOLD rising edges, then goes low.
  - key_press[0] reloads the hold counter: rst_out goes high on the next edge and stays high for RST_HOLD cycles.
  - A key_press[0] during an active hold restarts the count.
- Mode register:
  - key_press[1] increments mode, wrapping 3 to 0.
  - key_press[0] forces mode=0 and the chase register to 1.
  - If key_press[0] and key_press[1] occur in the same cycle, the soft reset wins and mode=0.
- Chase register: NUM_LEDS-bit one-hot, rotates left by 1 on each tick while mode==2; bit NUM_LEDS-1 wraps to bit 0. Holds its value in other modes.
- ledr, registered with 1 cycle of latency from the internal state:
  - mode 0 (alternate): even bits = clk_slow, odd bits = ~clk_slow.
  - mode 1 (all blink): all bits = clk_slow.
  - mode 2 (chase): ledr = chase register.
  - mode 3 (key monitor): ledr[NUM_KEYS-1:0] = key_db, ledr[NUM_LEDS-1] = clk_slow, all other bits 0.
- Reset mid-operation: rst low forces every register to its reset value immediately, independent of clk.
- Bounces shorter than DB_CYCLES never change key_db.

Test Plan:
Use CLK_HZ=1000, TICK_HZ=50 (HALF=10), DB_CYCLES=4, RST_HOLD=8, NUM_LEDS=10, NUM_KEYS=2 for all scenarios.
1. Release rst -> rst_out high for exactly 8 edges then low; clk_slow toggles every 10 cycles; tick is a 1-cycle pulse at each toggle; ledr = 0x155 / 0x2AA alternating (mode 0).
2. Drive key[1] low 3 cycles then high -> key_db[1] stays 0, no key_press, mode stays 0. Then hold key[1] low 12 cycles -> key_db[1]=1 at edge 6, key_press[1] is a single pulse, mode=1, ledr toggles between 0x3FF and 0x000.
3. Give four debounced key[1] presses -> mode steps 1, 2, 3, 0; in mode 3 with key[1] held, ledr = 0x202 when clk_slow=1 and 0x002 when clk_slow=0.
4. Enter mode 2 -> ledr steps 0x001, 0x002, ..., 0x200, 0x001, one step per tick, each change 1 cycle after tick.
5. Press key[0] in mode 2 -> rst_out high for 8 cycles starting the edge after key_press[0], mode=0, chase=0x001. Repeat with key_press[0] and key_press[1] in the same cycle -> mode=0. Press key[0] again at hold cycle 5 -> hold restarts at 8.
6. Assert rst mid-chase, asynchronously between edges -> ledr=0, mode=0, rst_out=1, clk_slow=0 without waiting for a clock edge.

Source files
------------

// File: rtl/heartbeat_ctrl.sv
// Board control block: key sync/debounce, stretched downstream reset,
// programmable slow clock with tick strobe, and a four-mode LED driver.

module hb_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic db_o,
  output logic press_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q, db_q, db_d, dly_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          synced;

  assign synced = ~sync2_q;

  // The update lands on the DB_CYCLES-th consecutive mismatch, which gives
  // DB_CYCLES+2 edges from raw change to db_o including the synchroniser.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (synced == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      db_d  = synced;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b0;
      dly_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      dly_q   <= db_q;
      press_q <= db_q & ~dly_q;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;
endmodule

module heartbeat_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int NUM_LEDS  = 10,
  parameter int NUM_KEYS  = 2,
  parameter int DB_CYCLES = 500_000,
  parameter int RST_HOLD  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_LEDS-1:0] ledr,
  output logic                clk_slow,
  output logic                tick,
  output logic                rst_out,
  output logic [1:0]          mode,
  output logic [NUM_KEYS-1:0] key_db,
  output logic [NUM_KEYS-1:0] key_press
);
  localparam int HALF   = CLK_HZ / (2 * TICK_HZ);
  localparam int DIV_W  = $clog2(HALF);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                clk_slow_q, clk_slow_d, tick_q, tick_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rst_out_q, rst_out_d;
  logic [1:0]          mode_q, mode_d;
  logic [NUM_LEDS-1:0] chase_q, chase_d, ledr_q, ledr_d;
  logic                div_wrap;

  hb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_KEYS-1:0] (
    .clk       (clk),
    .rst       (rst),
    .key_raw_i (key),
    .db_o      (key_db),
    .press_o   (key_press)
  );

  always_comb begin
    div_wrap   = (div_q == DIV_W'(HALF - 1));
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    clk_slow_d = clk_slow_q ^ div_wrap;
    tick_d     = div_wrap;

    hold_d    = key_press[0] ? HOLD_W'(RST_HOLD)
              : (hold_q != '0) ? hold_q - 1'b1 : '0;
    rst_out_d = (hold_d != '0);

    // Soft reset takes priority over a same-cycle mode step.
    mode_d = mode_q;
    if (key_press[1]) mode_d = mode_q + 2'd1;
    if (key_press[0]) mode_d = 2'd0;

    // Chase advances on the same edge clk_slow toggles.
    chase_d = chase_q;
    if (div_wrap && mode_q == 2'd2) chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
    if (key_press[0]) chase_d = NUM_LEDS'(1);

    ledr_d = '0;
    case (mode_q)
      2'd0: for (int i = 0; i < NUM_LEDS; i++) ledr_d[i] = i[0] ? ~clk_slow_q : clk_slow_q;
      2'd1: ledr_d = {NUM_LEDS{clk_slow_q}};
      2'd2: ledr_d = chase_q;
      default: begin
        ledr_d[NUM_KEYS-1:0] = key_db;
        ledr_d[NUM_LEDS-1]   = clk_slow_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      clk_slow_q <= 1'b0;
      tick_q     <= 1'b0;
      hold_q     <= HOLD_W'(RST_HOLD);
      rst_out_q  <= 1'b1;
      mode_q     <= 2'd0;
      chase_q    <= NUM_LEDS'(1);
      ledr_q     <= '0;
    end else begin
      div_q      <= div_d;
      clk_slow_q <= clk_slow_d;
      tick_q     <= tick_d;
      hold_q     <= hold_d;
      rst_out_q  <= rst_out_d;
      mode_q     <= mode_d;
      chase_q    <= chase_d;
      ledr_q     <= ledr_d;
    end
  end

  assign ledr     = ledr_q;
  assign clk_slow = clk_slow_q;
  assign tick     = tick_q;
  assign rst_out  = rst_out_q;
  assign mode     = mode_q;
endmodule
